mandelbrot_scheduler: RTL and testbench

- Sequences one shared `mandelbrot_alu` iteration datapath across a full WIDTH×HEIGHT raster, one iteration per clock.
- Latches a frame configuration (origin, step, iteration limit) on `start` and generates c per pixel incrementally.
- Drives z feedback to the ALU and emits one escape count per pixel on a valid/ready stream toward the video/framebuffer side.
- Replaces free-running diagonal stepping with a start/done-controlled, back-pressurable raster scan.

---
 rtl/mandelbrot_pkg.sv | 32 +++
 rtl/mandelbrot_coord_gen.sv | 92 +++++++++
 rtl/mandelbrot_scheduler.sv | 180 ++++++++++++++++++
 tb/tb_mandelbrot_scheduler.sv | 364 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mandelbrot_pkg.sv
// ============================================================================
// mandelbrot_pkg
// Shared FSM states, coordinate widths and reset origin for the scheduler.
// Revision: 1.0
// ============================================================================
`default_nettype none

package mandelbrot_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        EMIT = 2'd2
    } state_e;

    localparam int DEF_WIDTH    = 640;
    localparam int DEF_HEIGHT   = 480;
    localparam int DEF_BITWIDTH = 10;
    localparam int X_W          = $clog2(DEF_WIDTH);
    localparam int Y_W          = $clog2(DEF_HEIGHT);

    localparam logic [DEF_BITWIDTH-1:0] RST_CR0 = '0;
    localparam logic [DEF_BITWIDTH-1:0] RST_CI0 = '0;

    // A one-pixel dimension still needs a one-bit counter.
    function automatic int coord_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/mandelbrot_coord_gen.sv
// ============================================================================
// mandelbrot_coord_gen
// Raster x/y counters and incremental cr/ci accumulators with shadowed origin.
// Revision: 1.0
// ============================================================================
`default_nettype none

module mandelbrot_coord_gen
    import mandelbrot_pkg::*;
#(
    parameter int BITWIDTH = DEF_BITWIDTH,
    parameter int WIDTH    = DEF_WIDTH,
    parameter int HEIGHT   = DEF_HEIGHT
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         load_i,
    input  logic                         advance_i,
    input  logic [BITWIDTH-1:0]          cfg_cr0_i,
    input  logic [BITWIDTH-1:0]          cfg_ci0_i,
    input  logic [BITWIDTH-1:0]          cfg_step_i,
    output logic [BITWIDTH-1:0]          cr_o,
    output logic [BITWIDTH-1:0]          ci_o,
    output logic [coord_w(WIDTH)-1:0]    x_o,
    output logic [coord_w(HEIGHT)-1:0]   y_o,
    output logic                         last_o
);

    localparam int XW = coord_w(WIDTH);
    localparam int YW = coord_w(HEIGHT);
    localparam logic [XW-1:0] X_LAST = XW'(WIDTH - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(HEIGHT - 1);

    logic [BITWIDTH-1:0] cr_q, cr_d, ci_q, ci_d, cr0_q, cr0_d, step_q, step_d;
    logic [XW-1:0]       x_q, x_d;
    logic [YW-1:0]       y_q, y_d;

    always_comb begin
        cr_d   = cr_q;
        ci_d   = ci_q;
        cr0_d  = cr0_q;
        step_d = step_q;
        x_d    = x_q;
        y_d    = y_q;
        if (load_i) begin
            cr0_d  = cfg_cr0_i;
            step_d = cfg_step_i;
            cr_d   = cfg_cr0_i;
            ci_d   = cfg_ci0_i;
            x_d    = '0;
            y_d    = '0;
        end else if (advance_i) begin
            // Row wrap reloads from the shadowed origin, not the live config.
            if (x_q == X_LAST) begin
                x_d  = '0;
                y_d  = y_q + YW'(1);
                cr_d = cr0_q;
                ci_d = ci_q + step_q;
            end else begin
                x_d  = x_q + XW'(1);
                cr_d = cr_q + step_q;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cr_q   <= BITWIDTH'(RST_CR0);
            ci_q   <= BITWIDTH'(RST_CI0);
            cr0_q  <= BITWIDTH'(RST_CR0);
            step_q <= '0;
            x_q    <= '0;
            y_q    <= '0;
        end else begin
            cr_q   <= cr_d;
            ci_q   <= ci_d;
            cr0_q  <= cr0_d;
            step_q <= step_d;
            x_q    <= x_d;
            y_q    <= y_d;
        end
    end

    assign cr_o   = cr_q;
    assign ci_o   = ci_q;
    assign x_o    = x_q;
    assign y_o    = y_q;
    assign last_o = (x_q == X_LAST) && (y_q == Y_LAST);

endmodule

`default_nettype wire

// File: rtl/mandelbrot_scheduler.sv
// ============================================================================
// mandelbrot_scheduler
// Start/done raster scheduler for one shared Mandelbrot iteration ALU with a
// valid/ready escape-count stream. Optional abort input: MANDELBROT_ABORT_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module mandelbrot_scheduler
    import mandelbrot_pkg::*;
#(
    parameter int BITWIDTH = DEF_BITWIDTH,
    parameter int CTRWIDTH = 4,
    parameter int WIDTH    = DEF_WIDTH,
    parameter int HEIGHT   = DEF_HEIGHT
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
`ifdef MANDELBROT_ABORT_EN
    input  logic                         abort,
`endif
    input  logic [BITWIDTH-1:0]          cfg_cr0,
    input  logic [BITWIDTH-1:0]          cfg_ci0,
    input  logic [BITWIDTH-1:0]          cfg_step,
    input  logic [CTRWIDTH-1:0]          cfg_max_iter,
    output logic                         busy,
    output logic                         frame_done,
    output logic [BITWIDTH-1:0]          alu_cr,
    output logic [BITWIDTH-1:0]          alu_ci,
    output logic [BITWIDTH-1:0]          alu_zr,
    output logic [BITWIDTH-1:0]          alu_zi,
    input  logic [BITWIDTH-1:0]          alu_out_zr,
    input  logic [BITWIDTH-1:0]          alu_out_zi,
    input  logic                         alu_size,
    output logic                         pix_valid,
    input  logic                         pix_ready,
    output logic [CTRWIDTH-1:0]          pix_ctr,
    output logic [coord_w(WIDTH)-1:0]    pix_x,
    output logic [coord_w(HEIGHT)-1:0]   pix_y,
    output logic                         pix_last
);

    localparam int XW = coord_w(WIDTH);
    localparam int YW = coord_w(HEIGHT);

    state_e              state_q, state_d;
    logic [BITWIDTH-1:0] zr_q, zr_d, zi_q, zi_d;
    logic [CTRWIDTH-1:0] ctr_q, ctr_d, max_iter_q, max_iter_d;
    logic [CTRWIDTH-1:0] pix_ctr_q, pix_ctr_d;
    logic [XW-1:0]       pix_x_q, pix_x_d;
    logic [YW-1:0]       pix_y_q, pix_y_d;
    logic                pix_last_q, pix_last_d;
    logic                frame_done_q, frame_done_d;

    logic                w_load, w_advance, w_last;
    logic [XW-1:0]       w_x;
    logic [YW-1:0]       w_y;

    mandelbrot_coord_gen #(
        .BITWIDTH (BITWIDTH),
        .WIDTH    (WIDTH),
        .HEIGHT   (HEIGHT)
    ) u_coord_gen (
        .clk        (clk),
        .reset      (reset),
        .load_i     (w_load),
        .advance_i  (w_advance),
        .cfg_cr0_i  (cfg_cr0),
        .cfg_ci0_i  (cfg_ci0),
        .cfg_step_i (cfg_step),
        .cr_o       (alu_cr),
        .ci_o       (alu_ci),
        .x_o        (w_x),
        .y_o        (w_y),
        .last_o     (w_last)
    );

    always_comb begin
        state_d      = state_q;
        zr_d         = zr_q;
        zi_d         = zi_q;
        ctr_d        = ctr_q;
        max_iter_d   = max_iter_q;
        pix_ctr_d    = pix_ctr_q;
        pix_x_d      = pix_x_q;
        pix_y_d      = pix_y_q;
        pix_last_d   = pix_last_q;
        frame_done_d = 1'b0;
        w_load       = 1'b0;
        w_advance    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    max_iter_d = cfg_max_iter;
                    zr_d       = '0;
                    zi_d       = '0;
                    ctr_d      = '0;
                    w_load     = 1'b1;
                    state_d    = ITER;
                end
            end
            ITER: begin
                // Testing ctr before incrementing keeps it bounded by max_iter.
                if (!alu_size || (ctr_q == max_iter_q)) begin
                    pix_ctr_d  = ctr_q;
                    pix_x_d    = w_x;
                    pix_y_d    = w_y;
                    pix_last_d = w_last;
                    state_d    = EMIT;
                end else begin
                    zr_d  = alu_out_zr;
                    zi_d  = alu_out_zi;
                    ctr_d = ctr_q + CTRWIDTH'(1);
                end
            end
            EMIT: begin
                if (pix_ready) begin
                    if (pix_last_q) begin
                        frame_done_d = 1'b1;
                        state_d      = IDLE;
                    end else begin
                        zr_d      = '0;
                        zi_d      = '0;
                        ctr_d     = '0;
                        w_advance = 1'b1;
                        state_d   = ITER;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
`ifdef MANDELBROT_ABORT_EN
        if (abort && (state_q != IDLE)) begin
            frame_done_d = 1'b0;
            w_advance    = 1'b0;
            state_d      = IDLE;
        end
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            zr_q         <= '0;
            zi_q         <= '0;
            ctr_q        <= '0;
            max_iter_q   <= '0;
            pix_ctr_q    <= '0;
            pix_x_q      <= '0;
            pix_y_q      <= '0;
            pix_last_q   <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            zr_q         <= zr_d;
            zi_q         <= zi_d;
            ctr_q        <= ctr_d;
            max_iter_q   <= max_iter_d;
            pix_ctr_q    <= pix_ctr_d;
            pix_x_q      <= pix_x_d;
            pix_y_q      <= pix_y_d;
            pix_last_q   <= pix_last_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign busy       = (state_q != IDLE);
    assign pix_valid  = (state_q == EMIT);
    assign frame_done = frame_done_q;
    assign alu_zr     = zr_q;
    assign alu_zi     = zi_q;
    assign pix_ctr    = pix_ctr_q;
    assign pix_x      = pix_x_q;
    assign pix_y      = pix_y_q;
    assign pix_last   = pix_last_q;

endmodule

`default_nettype wire

// File: tb/tb_mandelbrot_scheduler.sv
// ============================================================================
// tb_mandelbrot_scheduler
// Directed self-checking bench on a 4x2 raster with a behavioural ALU.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_mandelbrot_scheduler;

    localparam int BW = 10;
    localparam int CW = 4;
    localparam int W  = 4;
    localparam int H  = 2;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
`ifdef MANDELBROT_ABORT_EN
    logic          abort = 1'b0;
`endif
    logic [BW-1:0] cfg_cr0 = '0, cfg_ci0 = '0, cfg_step = '0;
    logic [CW-1:0] cfg_max_iter = '0;
    logic          busy, frame_done, pix_valid, pix_last, alu_size;
    logic          pix_ready = 1'b1;
    logic [BW-1:0] alu_cr, alu_ci, alu_zr, alu_zi, alu_out_zr, alu_out_zi;
    logic [CW-1:0] pix_ctr;
    logic [1:0]    pix_x;
    logic [0:0]    pix_y;

    mandelbrot_scheduler #(.BITWIDTH(BW), .CTRWIDTH(CW), .WIDTH(W), .HEIGHT(H)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
`ifdef MANDELBROT_ABORT_EN
        .abort        (abort),
`endif
        .cfg_cr0      (cfg_cr0),
        .cfg_ci0      (cfg_ci0),
        .cfg_step     (cfg_step),
        .cfg_max_iter (cfg_max_iter),
        .busy         (busy),
        .frame_done   (frame_done),
        .alu_cr       (alu_cr),
        .alu_ci       (alu_ci),
        .alu_zr       (alu_zr),
        .alu_zi       (alu_zi),
        .alu_out_zr   (alu_out_zr),
        .alu_out_zi   (alu_out_zi),
        .alu_size     (alu_size),
        .pix_valid    (pix_valid),
        .pix_ready    (pix_ready),
        .pix_ctr      (pix_ctr),
        .pix_x        (pix_x),
        .pix_y        (pix_y),
        .pix_last     (pix_last)
    );

    always #5 clk = ~clk;

    // Integer fixed-point ALU: 0 = ideal, 1 = always escaped, 2 = never escapes.
    int alu_mode = 0;
    int m_zr, m_zi, m_cr, m_ci;
    always_comb begin
        m_zr       = int'($signed(alu_zr));
        m_zi       = int'($signed(alu_zi));
        m_cr       = int'($signed(alu_cr));
        m_ci       = int'($signed(alu_ci));
        alu_out_zr = BW'(m_zr * m_zr - m_zi * m_zi + m_cr);
        alu_out_zi = BW'(2 * m_zr * m_zi + m_ci);
        alu_size   = (m_zr * m_zr + m_zi * m_zi) <= 4;
        if (alu_mode == 1) alu_size = 1'b0;
        else if (alu_mode == 2) alu_size = 1'b1;
    end

    int n_asserts = 0;
    int n_fail = 0;

    int            res_n, fd_cnt, fd_cyc, cyc;
    int            res_x[8], res_y[8], res_cyc[8], res_ctr[8];
    logic          res_last[8];
    logic [BW-1:0] res_cr[8], res_ci[8];
    int            exp_ctr[8];
    int            g_cr0, g_ci0, g_step;

    task automatic start_frame(input int cr0, input int ci0, input int step, input int mi);
        @(negedge clk);
        cfg_cr0      = BW'(cr0);
        cfg_ci0      = BW'(ci0);
        cfg_step     = BW'(step);
        cfg_max_iter = CW'(mi);
        g_cr0 = cr0; g_ci0 = ci0; g_step = step;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Samples on negedges; stops after stop_n handshakes, or two cycles after frame_done.
    task automatic collect_frame(input int stop_n, input int budget);
        bit done = 0;
        res_n = 0; fd_cnt = 0; fd_cyc = -1; cyc = 0;
        for (int i = 0; i < budget && !done; i++) begin
            if (frame_done) begin
                fd_cnt++;
                if (fd_cyc < 0) fd_cyc = cyc;
            end
            if (pix_valid && pix_ready && res_n < 8) begin
                res_x[res_n] = int'(pix_x);  res_y[res_n] = int'(pix_y);
                res_ctr[res_n] = int'(pix_ctr); res_last[res_n] = pix_last;
                res_cr[res_n] = alu_cr;      res_ci[res_n] = alu_ci;
                res_cyc[res_n] = cyc;
                res_n++;
            end
            if (stop_n > 0 && res_n == stop_n) done = 1;
            else if (fd_cyc >= 0 && cyc >= fd_cyc + 2) done = 1;
            else begin
                @(negedge clk);
                cyc++;
            end
        end
        n_asserts++;
        if (!done) begin
            n_fail++;
            $display("FAIL collect_timeout: got %0d results, frame_done seen %0d, required completion within %0d cycles",
                     res_n, fd_cnt, budget);
        end
    endtask

    task automatic check_frame(input string tag, input bit chk_timing);
        n_asserts++;
        if (res_n !== 8) begin
            n_fail++;
            $display("FAIL %s count: got %0d results, required 8", tag, res_n);
        end
        for (int i = 0; i < res_n; i++) begin
            int            ex = i % W;
            int            ey = i / W;
            logic [BW-1:0] ecr = BW'(g_cr0 + ex * g_step);
            logic [BW-1:0] eci = BW'(g_ci0 + ey * g_step);
            n_asserts++;
            if (res_x[i] !== ex || res_y[i] !== ey || res_ctr[i] !== exp_ctr[i] || res_last[i] !== (i == 7)) begin
                n_fail++;
                $display("FAIL %s px%0d: got x=%0d y=%0d ctr=%0d last=%0d, required x=%0d y=%0d ctr=%0d last=%0d",
                         tag, i, res_x[i], res_y[i], res_ctr[i], res_last[i], ex, ey, exp_ctr[i], (i == 7));
            end
            n_asserts++;
            if (res_cr[i] !== ecr || res_ci[i] !== eci) begin
                n_fail++;
                $display("FAIL %s c%0d: got cr=%h ci=%h, required cr=%h ci=%h", tag, i, res_cr[i], res_ci[i], ecr, eci);
            end
            if (chk_timing && i > 0) begin
                n_asserts++;
                if (res_cyc[i] - res_cyc[i-1] !== exp_ctr[i] + 2) begin
                    n_fail++;
                    $display("FAIL %s spacing%0d: got %0d cycles, required %0d", tag, i,
                             res_cyc[i] - res_cyc[i-1], exp_ctr[i] + 2);
                end
            end
        end
        n_asserts++;
        if (fd_cnt !== 1 || (res_n == 8 && fd_cyc !== res_cyc[7] + 1)) begin
            n_fail++;
            $display("FAIL %s frame_done: got %0d pulses at cycle %0d, required 1 pulse at cycle %0d",
                     tag, fd_cnt, fd_cyc, (res_n == 8) ? res_cyc[7] + 1 : -1);
        end
    endtask

    task automatic set_exp_ideal();
        for (int i = 0; i < 8; i++) exp_ctr[i] = (i == 7) ? 3 : 1;
    endtask

    task automatic set_exp_const(input int v);
        for (int i = 0; i < 8; i++) exp_ctr[i] = v;
    endtask

    task automatic check_all_zero(input string tag);
        n_asserts++;
        if ({busy, frame_done, pix_valid, pix_last, pix_ctr, pix_x, pix_y} !== '0 ||
            {alu_cr, alu_ci, alu_zr, alu_zi} !== '0) begin
            n_fail++;
            $display("FAIL %s: got busy=%b fd=%b valid=%b last=%b ctr=%0d x=%0d y=%0d cr=%h ci=%h zr=%h zi=%h, required all 0",
                     tag, busy, frame_done, pix_valid, pix_last, pix_ctr, pix_x, pix_y, alu_cr, alu_ci, alu_zr, alu_zi);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        check_all_zero("reset_state");
        reset = 1'b0;
        @(negedge clk);
        check_all_zero("idle_after_reset");
    endtask

    task automatic test_raster();
        alu_mode = 0; pix_ready = 1'b1;
        start_frame(-4, -2, 1, 15);
        n_asserts++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL busy_after_start: got %b, required 1", busy);
        end
        collect_frame(0, 300);
        set_exp_ideal();
        check_frame("raster", 1'b1);
    endtask

    task automatic test_escape_all();
        alu_mode = 1;
        start_frame(-4, -2, 1, 15);
        collect_frame(0, 300);
        set_exp_const(0);
        check_frame("escape_all", 1'b1);
    endtask

    task automatic test_max_iter();
        alu_mode = 2;
        start_frame(-4, -2, 1, 5);
        collect_frame(0, 300);
        set_exp_const(5);
        check_frame("max_iter5", 1'b1);
        alu_mode = 0;
        start_frame(-4, -2, 1, 0);
        collect_frame(0, 300);
        set_exp_const(0);
        check_frame("max_iter0", 1'b1);
    endtask

    task automatic test_backpressure();
        alu_mode = 0; pix_ready = 1'b0;
        start_frame(-4, -2, 1, 15);
        for (int i = 0; i < 50 && !pix_valid; i++) @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            n_asserts++;
            if ({pix_valid, pix_ctr, pix_x, pix_y, alu_zr, alu_zi} !== {1'b1, 4'd1, 2'd0, 1'b0, 10'h3FC, 10'h3FE}) begin
                n_fail++;
                $display("FAIL stall%0d: got valid=%b ctr=%0d x=%0d y=%0d zr=%h zi=%h, required valid=1 ctr=1 x=0 y=0 zr=3fc zi=3fe",
                         i, pix_valid, pix_ctr, pix_x, pix_y, alu_zr, alu_zi);
            end
            @(negedge clk);
        end
        pix_ready = 1'b1;
        collect_frame(0, 300);
        set_exp_ideal();
        check_frame("backpressure", 1'b0);
    endtask

    task automatic test_reset_mid();
        alu_mode = 0;
        start_frame(-4, -2, 1, 15);
        collect_frame(3, 300);
        @(negedge clk);
        n_asserts++;
        if ({busy, pix_valid, pix_x} !== {1'b1, 1'b0, 2'd2}) begin
            n_fail++;
            $display("FAIL pre_reset_iter: got busy=%b valid=%b x=%0d, required busy=1 valid=0 x=2", busy, pix_valid, pix_x);
        end
        reset = 1'b1;
        #1;
        check_all_zero("async_reset");
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_asserts++;
            if (frame_done !== 1'b0 || busy !== 1'b0) begin
                n_fail++;
                $display("FAIL post_reset%0d: got fd=%b busy=%b, required 0 0", i, frame_done, busy);
            end
        end
        start_frame(-4, -2, 1, 15);
        collect_frame(0, 300);
        set_exp_ideal();
        check_frame("restart", 1'b1);
    endtask

    task automatic test_start_ignored();
        alu_mode = 0;
        start_frame(-4, -2, 1, 15);
        cfg_cr0 = 10'd100; cfg_ci0 = 10'd50; cfg_step = 10'd3; cfg_max_iter = 4'd0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        collect_frame(0, 300);
        set_exp_ideal();
        check_frame("start_ignored", 1'b0);
        n_asserts++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL no_queued_start: got busy=%b, required 0", busy);
        end
    endtask

    task automatic test_back_to_back();
        bit seen = 0;
        alu_mode = 1;
        start_frame(-4, -2, 1, 15);
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            if (frame_done) seen = 1;
        end
        n_asserts++;
        if (!seen || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_done: got seen=%b busy=%b, required seen=1 busy=0", seen, busy);
        end
        cfg_cr0 = BW'(-3); cfg_ci0 = BW'(-2); cfg_step = 10'd2; cfg_max_iter = 4'd7;
        g_cr0 = -3; g_ci0 = -2; g_step = 2;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n_asserts++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_start: got busy=%b, required 1", busy);
        end
        collect_frame(0, 300);
        set_exp_const(0);
        check_frame("back_to_back", 1'b1);
    endtask

`ifdef MANDELBROT_ABORT_EN
    task automatic test_abort();
        alu_mode = 0; pix_ready = 1'b0;
        start_frame(-4, -2, 1, 15);
        for (int i = 0; i < 50 && !pix_valid; i++) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        pix_ready = 1'b1;
        n_asserts++;
        if (pix_valid !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL abort: got valid=%b busy=%b, required 0 0", pix_valid, busy);
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_asserts++;
            if (frame_done !== 1'b0) begin
                n_fail++;
                $display("FAIL abort_fd%0d: got %b, required 0", i, frame_done);
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_raster();
        test_escape_all();
        test_max_iter();
        test_backpressure();
        test_reset_mid();
        test_start_ignored();
        test_back_to_back();
`ifdef MANDELBROT_ABORT_EN
        test_abort();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
